// File: rtl/xadc_drp_reader.sv
// xadc_drp_reader: DRP read master for the XADC temperature channel.
// On every end-of-conversion it issues one DRP read of DRP_ADDR and waits a
// bounded time for drdy_in. It then captures the 12-bit code and converts it
// to signed whole degrees Celsius. A free-running update counter presents
// the latest value to the display path once per UPDATE_CYCLES.
// Optional feature macro: XADC_AVG_EN. When it is defined, 2^AVG_LOG2
// successful reads are block-averaged before each conversion.
module xadc_drp_reader #(
    parameter logic [6:0] DRP_ADDR       = 7'h00,
    parameter int         TIMEOUT_CYCLES = 64,
    parameter int         UPDATE_CYCLES  = 100000000
`ifdef XADC_AVG_EN
    ,
    parameter int         AVG_LOG2       = 3
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        eoc_in,
    output logic        den_out,
    output logic [6:0]  daddr_out,
    input  logic        drdy_in,
    input  logic [15:0] do_in,
    output logic [11:0] raw_code,
    output logic [11:0] temp_c,
    output logic        temp_valid,
    output logic        timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int UW = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);
    localparam logic [UW-1:0] UPD_LAST = UW'(UPDATE_CYCLES - 1);
    localparam logic [UW-1:0] UPD_ONE  = UW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_CONV = 2'd3
    } state_t;

    // ((code * 504) >> 12) - 273, using a 21-bit unsigned product. The
    // result spans -273..230, so it always fits in 12-bit two's complement.
    function automatic logic [11:0] code_to_celsius(input logic [11:0] code);
        logic [20:0] prod;
        prod = {9'd0, code} * 21'd504;
        return {3'b000, prod[20:12]} - 12'd273;
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [TW-1:0]   to_cnt_r;
    logic [UW-1:0]   upd_cnt_r;
    logic            den_r;
    logic [11:0]     raw_r;
    logic [11:0]     latest_r;
    logic            have_sample_r;
    logic [11:0]     temp_r;
    logic            valid_r;
    logic            timeout_err_r;
    logic            read_ok_s;
    logic            timeout_hit_s;
    logic            block_last_s;
    logic            unused_low_bits_s;

    // The low nibble of the DRP word carries no ADC code bits.
    assign unused_low_bits_s = ^do_in[3:0];

`ifdef XADC_AVG_EN
    logic [12+AVG_LOG2-1:0] avg_sum_r;
    logic [12+AVG_LOG2-1:0] avg_sum_nxt_s;
    logic [AVG_LOG2-1:0]    avg_cnt_r;

    assign avg_sum_nxt_s = avg_sum_r + {{AVG_LOG2{1'b0}}, do_in[15:4]};
    assign block_last_s  = (avg_cnt_r == {AVG_LOG2{1'b1}});
`else
    assign block_last_s  = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; drdy_in is checked before the timeout so it wins a tie.
    always_comb begin
        state_nxt_s   = state_r;
        read_ok_s     = 1'b0;
        timeout_hit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (eoc_in) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (drdy_in) begin
                    read_ok_s = 1'b1;
                    if (block_last_s) begin
                        state_nxt_s = ST_CONV;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (to_cnt_r == TO_LAST) begin
                    timeout_hit_s = 1'b1;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_CONV: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Timeout counter: cleared in REQ, counts WAIT cycles without drdy_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= {TW{1'b0}};
        end else if (state_r == ST_REQ) begin
            to_cnt_r <= {TW{1'b0}};
        end else if ((state_r == ST_WAIT) && !drdy_in && !timeout_hit_s) begin
            to_cnt_r <= to_cnt_r + TO_ONE;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // DRP enable is high exactly while the FSM sits in REQ; the error is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            den_r         <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            den_r         <= (state_nxt_s == ST_REQ);
            timeout_err_r <= timeout_err_r | timeout_hit_s;
        end
    end

`ifdef XADC_AVG_EN
    // Accumulate successful reads; the block average goes to raw_code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_r     <= 12'd0;
            avg_sum_r <= {(12+AVG_LOG2){1'b0}};
            avg_cnt_r <= {AVG_LOG2{1'b0}};
        end else if (read_ok_s) begin
            avg_cnt_r <= avg_cnt_r + {{(AVG_LOG2-1){1'b0}}, 1'b1};
            if (block_last_s) begin
                raw_r     <= avg_sum_nxt_s[12+AVG_LOG2-1:AVG_LOG2];
                avg_sum_r <= {(12+AVG_LOG2){1'b0}};
            end else begin
                avg_sum_r <= avg_sum_nxt_s;
            end
        end else begin
            avg_sum_r <= avg_sum_r;
        end
    end
`else
    // Capture the ADC code on every successful read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_r <= 12'd0;
        end else if (read_ok_s) begin
            raw_r <= do_in[15:4];
        end else begin
            raw_r <= raw_r;
        end
    end
`endif

    // Convert the captured code in CONV and mark that a sample exists.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latest_r      <= 12'd0;
            have_sample_r <= 1'b0;
        end else if (state_r == ST_CONV) begin
            latest_r      <= code_to_celsius(raw_r);
            have_sample_r <= 1'b1;
        end else begin
            latest_r      <= latest_r;
        end
    end

    // Update period: present the latest value at terminal count if one exists.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_cnt_r <= {UW{1'b0}};
            temp_r    <= 12'd0;
            valid_r   <= 1'b0;
        end else if (upd_cnt_r == UPD_LAST) begin
            upd_cnt_r <= {UW{1'b0}};
            if (have_sample_r) begin
                temp_r  <= latest_r;
                valid_r <= 1'b1;
            end else begin
                valid_r <= 1'b0;
            end
        end else begin
            upd_cnt_r <= upd_cnt_r + UPD_ONE;
            valid_r   <= 1'b0;
        end
    end

    assign den_out     = den_r;
    assign daddr_out   = DRP_ADDR;
    assign raw_code    = raw_r;
    assign temp_c      = temp_r;
    assign temp_valid  = valid_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_xadc_drp_reader.sv
// Testbench for xadc_drp_reader: transaction-level timeline model plus
// directed and randomized DRP traffic. Build with +define+XADC_AVG_EN to
// exercise the block-average variant.
module tb_xadc_drp_reader;

    localparam int TMO   = 64;
    localparam int UPD   = 1000;
    localparam int AVG_N = 8;

    logic        clk;
    logic        rst_n;
    logic        eoc_in;
    logic        den_out;
    logic [6:0]  daddr_out;
    logic        drdy_in;
    logic [15:0] do_in;
    logic [11:0] raw_code;
    logic [11:0] temp_c;
    logic        temp_valid;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    xadc_drp_reader #(
        .DRP_ADDR(7'h00),
        .TIMEOUT_CYCLES(TMO),
        .UPDATE_CYCLES(UPD)
`ifdef XADC_AVG_EN
        ,
        .AVG_LOG2(3)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .eoc_in(eoc_in),
        .den_out(den_out),
        .daddr_out(daddr_out),
        .drdy_in(drdy_in),
        .do_in(do_in),
        .raw_code(raw_code),
        .temp_c(temp_c),
        .temp_valid(temp_valid),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model (timeline of read transactions) ----
    int k;              // edges since reset release
    int ticks = 0;      // update ticks seen (monotonic, survives reset)
    bit busy, done_rd, conv_pending;
    int req_edge, free_edge, conv_edge;
    int m_raw, m_latest, m_temp, acc_sum, acc_n;
    bit m_have, m_err, exp_den, exp_valid;

    function automatic int celsius(input int code);
        return (code * 504) / 4096 - 273;
    endfunction

    task automatic model_reset();
        k = 0; busy = 0; done_rd = 0; conv_pending = 0;
        m_raw = 0; m_latest = 0; m_temp = 0; m_have = 0; m_err = 0;
        exp_den = 0; exp_valid = 0; acc_sum = 0; acc_n = 0;
    endtask

    task automatic accept_code(input int code);
        bit convert;
        convert = 1'b1;
`ifdef XADC_AVG_EN
        acc_sum += code;
        acc_n++;
        convert = (acc_n == AVG_N);
        if (convert) begin
            code = acc_sum / AVG_N;
            acc_sum = 0;
            acc_n = 0;
        end
`endif
        if (convert) begin
            m_raw = code;
            conv_pending = 1;
            conv_edge = k + 1;
            free_edge = k + 2;
        end else begin
            free_edge = k + 1;
        end
    endtask

    // Model: advances once per clock edge from the sampled inputs.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                exp_valid = 0;
                if ((k % UPD) == UPD - 1) begin
                    ticks++;
                    if (m_have) begin
                        m_temp = m_latest;
                        exp_valid = 1;
                    end
                end
                if (conv_pending && conv_edge == k) begin
                    m_latest = celsius(m_raw);
                    m_have = 1;
                    conv_pending = 0;
                end
                exp_den = 0;
                if (busy && done_rd && k >= free_edge) busy = 0;
                if (!busy) begin
                    if (eoc_in) begin
                        busy = 1; done_rd = 0; req_edge = k; exp_den = 1;
                    end
                end else if (!done_rd && k >= req_edge + 2) begin
                    if (drdy_in) begin
                        accept_code(int'(do_in[15:4]));
                        done_rd = 1;
                    end else if (k == req_edge + 1 + TMO) begin
                        m_err = 1;
                        done_rd = 1;
                        free_edge = k + 1;
                    end
                end
                k++;
            end
        end
    end

    // ---------------- compare process ---------------------------------------
    int obs_den = 0;
    int obs_valid = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("den_out", {31'd0, den_out}, {31'd0, exp_den});
                chk("daddr_out", {25'd0, daddr_out}, 32'd0);
                chk("raw_code", {20'd0, raw_code}, m_raw);
                chk("temp_c", {20'd0, temp_c}, {20'd0, m_temp[11:0]});
                chk("temp_valid", {31'd0, temp_valid}, {31'd0, exp_valid});
                chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_err});
                if (den_out) obs_den++;
                if (temp_valid) obs_valid++;
            end
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic do_read(input logic [15:0] data, input int delay, input bit extra_eoc);
        int g;
        int d0;
        d0 = obs_den;
        @(negedge clk); eoc_in = 1'b1;
        @(negedge clk); eoc_in = 1'b0;
        g = 0;
        while (!den_out && g < 8) begin
            @(negedge clk);
            g++;
        end
        if (g >= 8) chk("den_wait_bound", 32'd0, 32'd1);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            eoc_in = extra_eoc && (i == 0);
        end
        eoc_in = 1'b0;
        drdy_in = 1'b1;
        do_in = data;
        @(negedge clk);
        drdy_in = 1'b0;
        do_in = 16'($urandom);
        repeat (3) @(negedge clk);
        chk("den_pulses_per_read", obs_den - d0, 32'd1);
    endtask

    task automatic wait_tick();
        int t0;
        int g;
        t0 = ticks;
        g = 0;
        while (ticks == t0 && g < UPD + 100) begin
            @(negedge clk);
            g++;
        end
        if (ticks == t0) chk("tick_wait_bound", 32'd0, 32'd1);
    endtask

    task automatic reset_pulse();
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        chk("rst_den", {31'd0, den_out}, 32'd0);
        chk("rst_raw", {20'd0, raw_code}, 32'd0);
        chk("rst_temp", {20'd0, temp_c}, 32'd0);
        chk("rst_valid", {31'd0, temp_valid}, 32'd0);
        chk("rst_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_daddr", {25'd0, daddr_out}, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // ---------------- main sequence -----------------------------------------
    initial begin
        int v0;
        int rate;
        rst_n = 1'b0; eoc_in = 1'b0; drdy_in = 1'b0; do_in = 16'h0000;
        #12;
        chk("por_den", {31'd0, den_out}, 32'd0);
        chk("por_temp", {20'd0, temp_c}, 32'd0);
        chk("por_daddr", {25'd0, daddr_out}, 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;

`ifdef XADC_AVG_EN
        for (int c = 2456; c <= 2462; c++) do_read({c[11:0], 4'h0}, 2, 1'b0);
        wait_tick();
        chk("avg7_no_valid", obs_valid, 32'd0);
        chk("avg7_temp", {20'd0, temp_c}, 32'd0);
        chk("avg7_raw", {20'd0, raw_code}, 32'd0);
        do_read(16'h99F0, 2, 1'b0);
        chk("avg8_raw", {20'd0, raw_code}, 32'd2459);
        wait_tick();
        chk("avg8_valid", {31'd0, temp_valid}, 32'd1);
        chk("avg8_temp", {20'd0, temp_c}, 32'd29);
`else
        // No reads before the first tick.
        wait_tick();
        chk("no_read_valid", obs_valid, 32'd0);
        chk("no_read_temp", {20'd0, temp_c}, 32'd0);
        // Basic read: code 2458 -> 29 C.
        do_read(16'h99A0, 3, 1'b0);
        chk("read1_raw", {20'd0, raw_code}, 32'h99A);
        v0 = obs_valid;
        wait_tick();
        chk("read1_valid", {31'd0, temp_valid}, 32'd1);
        chk("read1_temp", {20'd0, temp_c}, 32'd29);
        @(negedge clk);
        chk("read1_valid_one_cycle", obs_valid - v0, 32'd1);
        // Conversion limits.
        do_read(16'h0000, 1, 1'b0);
        wait_tick();
        chk("code0_temp", {20'd0, temp_c}, 32'hEEF);
        do_read(16'hFFF0, 5, 1'b0);
        wait_tick();
        chk("code4095_temp", {20'd0, temp_c}, 32'd230);
        // Timeout: no drdy.
        @(negedge clk); eoc_in = 1'b1;
        @(negedge clk); eoc_in = 1'b0;
        repeat (TMO + 6) @(negedge clk);
        chk("timeout_set", {31'd0, timeout_err}, 32'd1);
        chk("timeout_temp_kept", {20'd0, temp_c}, 32'd230);
        do_read(16'h99A0, 2, 1'b0);
        wait_tick();
        chk("after_timeout_temp", {20'd0, temp_c}, 32'd29);
        chk("timeout_sticky", {31'd0, timeout_err}, 32'd1);
        // Second eoc during WAIT produces no extra den (checked in do_read).
        do_read(16'h5550, 4, 1'b1);
        chk("extra_eoc_raw", {20'd0, raw_code}, 32'h555);
        // Reset in WAIT, then a late drdy.
        @(negedge clk); eoc_in = 1'b1;
        @(negedge clk); eoc_in = 1'b0;
        repeat (2) @(negedge clk);
        reset_pulse();
        v0 = obs_den;
        @(negedge clk); drdy_in = 1'b1; do_in = 16'hFFF0;
        @(negedge clk); drdy_in = 1'b0;
        repeat (5) @(negedge clk);
        chk("late_drdy_raw", {20'd0, raw_code}, 32'd0);
        chk("late_drdy_no_den", obs_den - v0, 32'd0);
        do_read(16'h1230, 2, 1'b0);
        chk("post_reset_raw", {20'd0, raw_code}, 32'h123);
`endif

        // Randomized traffic, segments with different drdy rates.
        for (int s = 0; s < 12; s++) begin
            rate = $urandom_range(0, 2);
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                eoc_in  = ($urandom_range(0, 11) == 0);
                drdy_in = (rate == 0) ? 1'b0 :
                          (rate == 1) ? ($urandom_range(0, 39) == 0) :
                                        ($urandom_range(0, 3) == 0);
                do_in   = 16'($urandom);
            end
        end
        @(negedge clk); eoc_in = 1'b0; drdy_in = 1'b0;
        wait_tick();
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
